// File: rtl/reg32_pkg.sv
// Shared types and constants for the 32-bit register-bank serializer.
package reg32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned REG_WIDTH = 32;

    // Bit counter width; never below one bit so narrow words still count.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 32'd1 : 32'($clog2(w));
    endfunction

endpackage

// File: rtl/reg32_serializer_if.sv
// Load/serial-out bundle between a word source and the serializer.
interface reg32_serializer_if
    import reg32_pkg::*;
#(
    parameter int unsigned WIDTH = REG_WIDTH
) ();

    logic             load;
    logic [WIDTH-1:0] D;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output load, D, shift_en,
        input  sout, sout_valid, busy, done
    );

    modport slave (
        input  load, D, shift_en,
        output sout, sout_valid, busy, done
    );

endinterface

// File: rtl/reg32_bitcnt.sv
// Loadable down-counter with enable and zero flag; saturates at zero.
module reg32_bitcnt
    import reg32_pkg::*;
#(
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [CW-1:0] val_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reg32_serializer.sv
// Parallel-to-serial reader: captures a word on load, shifts it out one bit
// per enabled clock, then pulses done for one cycle.
module reg32_serializer
    import reg32_pkg::*;
#(
    parameter int unsigned WIDTH     = REG_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               clear,
    reg32_serializer_if.slave  bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic             sout_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_en;

    assign cnt_load = (state_q == ST_IDLE) && bus.load;
    assign cnt_en   = (state_q == ST_SHIFT) && bus.shift_en && !cnt_zero;

    reg32_bitcnt #(.CW(CW)) u_bitcnt (
        .clk    (clk),
        .clear  (clear),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .val_i  (CW'(WIDTH - 1)),
        .zero_o (cnt_zero)
    );

    // Outputs are computed alongside the next state so they are pure flops.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.load) begin
                        state_q <= ST_SHIFT;
                        sreg_q  <= bus.D;
                        sout_q  <= MSB_FIRST ? bus.D[WIDTH-1] : bus.D[0];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bus.shift_en) begin
                        if (cnt_zero) begin
                            state_q <= ST_DONE;
                            sreg_q  <= '0;
                            sout_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            sreg_q <= MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                                : {1'b0, sreg_q[WIDTH-1:1]};
                            sout_q <= MSB_FIRST ? sreg_q[WIDTH-2] : sreg_q[1];
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    sreg_q  <= '0;
                    sout_q  <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sout       = sout_q;
    assign bus.sout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_reg32_serializer.sv
// Bench for reg32_serializer: MSB-first and LSB-first instances share stimulus
// and are checked against a per-word bit-order model.
module tb_reg32_serializer;
    import reg32_pkg::*;

    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg32_serializer_if #(.WIDTH(32)) m_if ();
    reg32_serializer_if #(.WIDTH(32)) l_if ();

    reg32_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .clear (clear),
        .bus   (m_if.slave)
    );

    reg32_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .clear (clear),
        .bus   (l_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [31:0] d, input logic en);
        m_if.load = ld;  l_if.load = ld;
        m_if.D = d;      l_if.D = d;
        m_if.shift_en = en; l_if.shift_en = en;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected nibble is {sout, sout_valid, busy, done}.
    task automatic chk_both(input string tag, input logic [3:0] m_exp, input logic [3:0] l_exp);
        chk({tag, "_msb"}, 32'({m_if.sout, m_if.sout_valid, m_if.busy, m_if.done}), 32'(m_exp));
        chk({tag, "_lsb"}, 32'({l_if.sout, l_if.sout_valid, l_if.busy, l_if.done}), 32'(l_exp));
    endtask

    // One word: load, then per cycle the MSB instance must show data[31-k] and
    // the LSB instance data[k], k advancing only on edges with shift_en=1.
    task automatic xfer(input logic [31:0] data, input int st_lo, input int st_hi,
                        input bit rnd, input bit noise);
        int k = 0;
        int c = 1;
        int stalls = 0;
        int guard = 0;
        bit en;
        bit ld;
        logic [31:0] dv;
        drive(1'b1, data, 1'b1);
        step();
        while (k < 32 && guard < 300) begin
            chk_both("shift", {data[31-k], 3'b110}, {data[k], 3'b110});
            en = rnd ? ($urandom_range(0, 99) >= 25) : !(c >= st_lo && c <= st_hi);
            if (!en) stalls++;
            ld = noise && (rnd ? ($urandom_range(0, 3) == 0) : (c == 10));
            dv = (noise && !rnd) ? 32'hFFFF_FFFF : $urandom;
            drive(ld, dv, en);
            step();
            if (en) k++;
            c++;
            guard++;
        end
        chk("bits_sent", 32'(k), 32'd32);
        chk("done_cycle", 32'(c), 32'(33 + stalls));
        chk_both("done", 4'b0011, 4'b0011);
        drive(noise, 32'hFFFF_FFFF, 1'b1);
        step();
        chk_both("idle", 4'b0000, 4'b0000);
        drive(1'b0, $urandom, 1'b0);
    endtask

    initial begin
        clear = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1);
        repeat (3) step();
        chk_both("reset", 4'b0000, 4'b0000);
        clear = 1'b1;
        drive(1'b0, 32'hDEAD_BEEF, 1'b1);
        step();
        step();
        chk_both("post_reset_idle", 4'b0000, 4'b0000);

        xfer(32'hA5A5_0F0F, 100, 0, 1'b0, 1'b0);
        xfer(32'hA5A5_0F0F, 5, 7, 1'b0, 1'b0);
        xfer(32'hA5A5_0F0F, 100, 0, 1'b0, 1'b1);
        xfer(32'hFFFF_FFFF, 100, 0, 1'b0, 1'b0);
        xfer(32'h0000_0003, 100, 0, 1'b0, 1'b0);

        // Reset in the middle of a word.
        drive(1'b1, 32'hA5A5_0F0F, 1'b1);
        step();
        for (int i = 1; i < 12; i++) begin
            drive(1'b0, $urandom, 1'b1);
            step();
        end
        chk("mid_valid_msb", 32'(m_if.sout_valid), 32'd1);
        #1 clear = 1'b0;
        #1;
        chk_both("async_clear", 4'b0000, 4'b0000);
        drive(1'b1, 32'hFFFF_FFFF, 1'b1);
        step();
        step();
        chk_both("held_clear", 4'b0000, 4'b0000);
        clear = 1'b1;
        drive(1'b0, 32'hFFFF_FFFF, 1'b1);
        step();
        chk_both("after_clear", 4'b0000, 4'b0000);
        step();
        chk_both("no_done", 4'b0000, 4'b0000);
        xfer(32'h0000_0001, 100, 0, 1'b0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            xfer($urandom, 0, 0, 1'b1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
